// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// The optional statistics counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W       = 4;   // wide enough for the largest legal MAX_WAIT (15)
  localparam int STAT_W       = 32;

  typedef enum logic [1:0] {
    PIPE  = 2'd0,
    DBG   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline, debug and memory-port signals around the arbiter.
// slave is the arbiter's view; master is the requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_stall;
    logic [DATA_W-1:0] p_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        input  mem_rdata,
        output p_stall, p_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        output mem_rdata,
        input  p_stall, p_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Debug starvation counter: counts cycles the debug port loses to the pipeline,
// saturating at MAX_WAIT; sat tells the arbiter to hand the port to debug.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the MEM-stage pipeline and a debug/loader
// port. Define MEM_ARB_STATS_EN to add saturating stall/grant counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stall_cnt,
    output logic [STAT_W-1:0]   dbg_cnt
`endif
);

    arb_state_e        state;
    logic              rvalid_q;
    logic              pipe_rd_q;

    logic              wait_sat;
    logic              wait_inc;
    logic              wait_clr;
    logic              go_dbg;

    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              we_mux;
    logic              re_mux;
    logic              gnt;
    logic              stall;
    logic              rvalid;

    assign go_dbg   = (state == PIPE) && bus.d_req && (!bus.p_req || wait_sat);
    assign wait_inc = (state == PIPE) && bus.d_req && bus.p_req;
    assign wait_clr = !bus.d_req || go_dbg;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .inc (wait_inc),
        .clr (wait_clr),
        .sat (wait_sat)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
        re_mux    = 1'b0;
        gnt       = 1'b0;
        stall     = 1'b0;
        case (state)
            PIPE: begin
                if (bus.p_req) begin
                    addr_mux  = bus.p_addr;
                    wdata_mux = bus.p_wdata;
                    we_mux    = bus.p_we;
                    re_mux    = !bus.p_we;
                end
            end
            DBG: begin
                stall = bus.p_req;
                if (bus.d_req) begin
                    gnt       = 1'b1;
                    addr_mux  = bus.d_addr;
                    wdata_mux = bus.d_wdata;
                    we_mux    = bus.d_we;
                    re_mux    = !bus.d_we;
                end
            end
            DRAIN: begin
                stall = bus.p_req;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PIPE;
            rvalid_q  <= 1'b0;
            pipe_rd_q <= 1'b0;
        end else begin
            rvalid_q  <= gnt && !bus.d_we;
            pipe_rd_q <= (state == PIPE) && re_mux;
            case (state)
                PIPE: begin
                    if (go_dbg) state <= DBG;
                end
                DBG: begin
                    if (!bus.d_req) begin
                        state <= PIPE;
                    end else if (!bus.d_lock) begin
                        state <= bus.d_we ? PIPE : DRAIN;
                    end
                end
                DRAIN:   state <= PIPE;
                default: state <= PIPE;
            endcase
        end
    end

    // A reset landing while a debug read is in flight must suppress its return pulse.
    assign rvalid = rvalid_q && !rst;

    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_we    = we_mux;
    assign bus.mem_re    = re_mux;
    assign bus.d_gnt     = gnt;
    assign bus.p_stall   = stall;
    assign bus.d_rvalid  = rvalid;
    assign bus.d_rdata   = rvalid    ? bus.mem_rdata : '0;
    assign bus.p_rdata   = pipe_rd_q ? bus.mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            dbg_cnt   <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, stall);
            dbg_cnt   <= sat_inc(dbg_cnt, gnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: pipeline vector table plus hand-written debug
// sequences; read data is checked against scoreboard queues.
module tb_mem_port_arbiter;

    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] dbg_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .dbg_cnt   (dbg_cnt)
`endif
    );

    // Memory model: write on the issuing edge, read data one cycle after mem_re.
    logic [31:0] mem [0:255];
    logic [31:0] mem_q = 32'hA5A5_A5A5;
    assign bus.mem_rdata = mem_q;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_re) mem_q <= mem[bus.mem_addr[7:0]];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int rv_seen = 0;
    logic [31:0] dq[$];
    logic [31:0] pq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic drive_idle();
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        if (pq.size() != 0) check("p_rdata", bus.p_rdata, pq.pop_front());
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Debug read return monitor.
    always @(negedge clk) begin
        if (bus.d_rvalid === 1'b1) begin
            rv_seen++;
            if (dq.size() == 0) chk1("d_rvalid_spurious", bus.d_rvalid, 1'b0);
            else check("d_rdata", bus.d_rdata, dq.pop_front());
        end
    end

    typedef struct {
        logic        p_req;
        logic        p_we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic        exp_re;
        logic [31:0] exp_addr;
        logic        has_rd;
        logic [31:0] rd_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h1234,      1'b1, 1'b0, 32'h20, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h10, 32'hDEAD,      1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b1, 32'h10, 1'b1, 32'hDEAD};
        vecs[4] = '{1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b1, 32'h20, 1'b1, 32'h1234};
        vecs[5] = '{1'b1, 1'b1, 32'hFC, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFC, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'hFC, 32'h0,         1'b0, 1'b1, 32'hFC, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{1'b0, 1'b0, 32'h00, 32'h0,         1'b0, 1'b0, 32'h00, 1'b0, 32'h0};

        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        sample();
        chk1("rst_d_gnt", bus.d_gnt, 1'b0);
        chk1("rst_d_rvalid", bus.d_rvalid, 1'b0);
        chk1("rst_p_stall", bus.p_stall, 1'b0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_p_rdata", bus.p_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Pipeline-only vectors: port follows the pipeline combinationally.
        for (int i = 0; i < 8; i++) begin
            bus.p_req = vecs[i].p_req; bus.p_we = vecs[i].p_we;
            bus.p_addr = vecs[i].addr; bus.p_wdata = vecs[i].wdata;
            sample();
            chk1($sformatf("v%0d_mem_we", i), bus.mem_we, vecs[i].exp_we);
            chk1($sformatf("v%0d_mem_re", i), bus.mem_re, vecs[i].exp_re);
            check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
            chk1($sformatf("v%0d_p_stall", i), bus.p_stall, 1'b0);
            chk1($sformatf("v%0d_d_gnt", i), bus.d_gnt, 1'b0);
            if (vecs[i].exp_we) check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
            if (vecs[i].has_rd) pq.push_back(vecs[i].rd_data);
            next_cycle();
        end

        // Starved debug read: grant after MW cycles of pipeline priority.
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h80; bus.p_wdata = 32'h5555;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        dq.push_back(32'h1234);
        for (int k = 0; k < 9; k++) begin
            sample();
            chk1($sformatf("s1_gnt_k%0d", k), bus.d_gnt, k == MW + 1);
            chk1($sformatf("s1_stall_k%0d", k), bus.p_stall, (k == MW + 1) || (k == MW + 2));
            chk1($sformatf("s1_rvalid_k%0d", k), bus.d_rvalid, k == MW + 2);
            if (k == MW + 1) begin
                check("s1_dbg_addr", bus.mem_addr, 32'h20);
                chk1("s1_dbg_re", bus.mem_re, 1'b1);
            end
            if (k <= MW || k > MW + 2) chk1($sformatf("s1_pipe_we_k%0d", k), bus.mem_we, 1'b1);
            next_cycle();
            if (k == MW + 1) bus.d_req = 1'b0;
        end
`ifdef MEM_ARB_STATS_EN
        check("stats_stall_cnt", stall_cnt, 32'd2);
        check("stats_dbg_cnt", dbg_cnt, 32'd1);
`endif
        drive_idle();

        // Dropping d_req clears the wait count; starvation restarts from zero.
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h84; bus.p_wdata = 32'h7777;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h60; bus.d_wdata = 32'h6060;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk1($sformatf("s2_gnt_k%0d", k), bus.d_gnt, k == MW + 4);
            chk1($sformatf("s2_stall_k%0d", k), bus.p_stall, k == MW + 4);
            next_cycle();
            bus.d_req = (k + 1 != 2) && (k + 1 <= MW + 4);
        end
        drive_idle();

        // Idle pipeline: debug write granted next cycle, then back to PIPE.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h44; bus.d_wdata = 32'hBEEF;
        sample();
        chk1("s3_gnt_c0", bus.d_gnt, 1'b0);
        chk1("s3_we_c0", bus.mem_we, 1'b0);
        next_cycle();
        sample();
        chk1("s3_gnt_c1", bus.d_gnt, 1'b1);
        chk1("s3_we_c1", bus.mem_we, 1'b1);
        check("s3_addr_c1", bus.mem_addr, 32'h44);
        check("s3_wdata_c1", bus.mem_wdata, 32'hBEEF);
        chk1("s3_stall_c1", bus.p_stall, 1'b0);
        next_cycle();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h44;
        sample();
        chk1("s3_stall_c2", bus.p_stall, 1'b0);
        chk1("s3_re_c2", bus.mem_re, 1'b1);
        chk1("s3_gnt_c2", bus.d_gnt, 1'b0);
        pq.push_back(32'hBEEF);
        next_cycle();
        drive_idle();
        sample();
        chk1("idle_we", bus.mem_we, 1'b0);
        chk1("idle_re", bus.mem_re, 1'b0);
        check("idle_addr", bus.mem_addr, 32'h0);
        next_cycle();

        // Locked burst of three debug writes while the pipeline is waiting.
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h88; bus.p_wdata = 32'h9999;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b1;
        bus.d_addr = 32'h50; bus.d_wdata = 32'h5000;
        for (int k = 0; k <= MW; k++) begin
            sample();
            chk1($sformatf("s4_wait_gnt_k%0d", k), bus.d_gnt, 1'b0);
            next_cycle();
        end
        for (int j = 0; j < 3; j++) begin
            sample();
            chk1($sformatf("s4_gnt_j%0d", j), bus.d_gnt, 1'b1);
            chk1($sformatf("s4_stall_j%0d", j), bus.p_stall, 1'b1);
            chk1($sformatf("s4_we_j%0d", j), bus.mem_we, 1'b1);
            check($sformatf("s4_addr_j%0d", j), bus.mem_addr, 32'h50 + 32'(4 * j));
            next_cycle();
            bus.d_addr = 32'h50 + 32'(4 * (j + 1));
            bus.d_wdata = 32'h5000 + 32'(j + 1);
            bus.d_lock = (j + 1 < 2);
        end
        drive_idle();
        bus.p_req = 1'b1; bus.p_addr = 32'h58;
        sample();
        chk1("s4_post_stall", bus.p_stall, 1'b0);
        chk1("s4_post_gnt", bus.d_gnt, 1'b0);
        chk1("s4_post_re", bus.mem_re, 1'b1);
        pq.push_back(32'h5002);
        next_cycle();
        bus.p_addr = 32'h50;
        sample();
        pq.push_back(32'h5000);
        next_cycle();
        drive_idle();
        sample();
        next_cycle();

        // Reset in the cycle after a debug read grant cancels d_rvalid.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        sample();
        next_cycle();
        sample();
        chk1("s5_gnt", bus.d_gnt, 1'b1);
        chk1("s5_re", bus.mem_re, 1'b1);
        next_cycle();
        rst = 1'b1;
        bus.d_req = 1'b0;
        sample();
        chk1("s5_rst_rvalid", bus.d_rvalid, 1'b0);
        check("s5_rst_rdata", bus.d_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        sample();
        chk1("s5_post_rvalid", bus.d_rvalid, 1'b0);
        chk1("s5_post_gnt", bus.d_gnt, 1'b0);
        chk1("s5_post_stall", bus.p_stall, 1'b0);
        check("s5_post_d_rdata", bus.d_rdata, 32'h0);
        check("s5_post_p_rdata", bus.p_rdata, 32'h0);
        chk1("s5_post_we", bus.mem_we, 1'b0);
        chk1("s5_post_re", bus.mem_re, 1'b0);
        check("s5_post_addr", bus.mem_addr, 32'h0);
`ifdef MEM_ARB_STATS_EN
        check("s5_stall_cnt", stall_cnt, 32'd0);
        check("s5_dbg_cnt", dbg_cnt, 32'd0);
`endif
        next_cycle();
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h90; bus.p_wdata = 32'h1;
        sample();
        chk1("s5_pipe_stall", bus.p_stall, 1'b0);
        chk1("s5_pipe_we", bus.mem_we, 1'b1);
        check("s5_pipe_addr", bus.mem_addr, 32'h90);
        next_cycle();
        drive_idle();
        sample();

        check("rvalid_pulses", 32'(rv_seen), 32'd1);
        check("dq_left", 32'(dq.size()), 32'd0);
        check("pq_left", 32'(pq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
